// File: rtl/sisc_pkg.sv
// rtl/sisc_pkg.sv - shared types and constants for the SISC trace monitor
//
// Contents:
//   mon_state_t   : monitor FSM states (IDLE, RUN, HALTED, TIMEOUT)
//   OP_W          : opcode width; the opcode occupies ir[IR_W-1 -: OP_W]
//   HALT_OP_DEF   : default halt opcode
//   trace_entry_t : {pc, ir} trace entry at the default 16/32-bit widths

package sisc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_HALTED  = 2'd2,
        ST_TIMEOUT = 2'd3
    } mon_state_t;

    // Opcode field sits in the top OP_W bits of the instruction word.
    localparam int OP_W = 4;
    localparam logic [OP_W-1:0] HALT_OP_DEF = 4'hF;

    localparam int DEF_PC_W = 16;
    localparam int DEF_IR_W = 32;

    typedef struct packed {
        logic [DEF_PC_W-1:0] pc;
        logic [DEF_IR_W-1:0] ir;
    } trace_entry_t;

endpackage

// File: rtl/sisc_trace_ram.sv
// rtl/sisc_trace_ram.sv - DEPTH x W trace storage, one write port, registered read
//
// Ports:
//   clk      : rising-edge clock
//   i_we     : write enable
//   i_waddr  : write address
//   i_wdata  : write data
//   i_raddr  : read address
//   o_rdata  : data at i_raddr, one cycle later; a same-cycle write to the
//              read slot returns the old contents
//
// The array carries no reset; validity is tracked by the owner.

module sisc_trace_ram
    import sisc_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int W     = 48
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [W-1:0]             i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [W-1:0]             o_rdata
);

    logic [W-1:0] r_mem [DEPTH];
    logic [W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/sisc_trace_mon.sv
// rtl/sisc_trace_mon.sv - SISC run monitor: circular retire trace, counters, halt/timeout
//
// Optional feature macro: SISC_TRACE_DEDUP_EN (suppress a write equal to the
// most recently written entry; the instruction is still counted).
//
// Ports:
//   clk, rst_f (async, active-low), clear (sync restart to IDLE)
//   ir_valid, pc, ir     : retire tap from the core
//   rd_idx               : trace read index, 0 = oldest held entry
//   rd_data              : {pc, ir} at rd_idx, one cycle latency, 0 if rd_idx >= entries
//   entries, overflow    : valid entry count (saturates at DEPTH), sticky overwrite flag
//   instr_count          : retired instructions, saturating
//   done, halted, timed_out : terminal status

module sisc_trace_mon
    import sisc_pkg::*;
#(
    parameter int              DEPTH       = 16,
    parameter int              PC_W        = 16,
    parameter int              IR_W        = 32,
    parameter int              CNT_W       = 16,
    parameter logic [OP_W-1:0] HALT_OP     = HALT_OP_DEF,
    parameter int              TIMEOUT_CYC = 1000
) (
    input  logic                       clk,
    input  logic                       rst_f,
    input  logic                       clear,
    input  logic                       ir_valid,
    input  logic [PC_W-1:0]            pc,
    input  logic [IR_W-1:0]            ir,
    input  logic [$clog2(DEPTH)-1:0]   rd_idx,
    output logic [PC_W+IR_W-1:0]       rd_data,
    output logic [$clog2(DEPTH):0]     entries,
    output logic                       overflow,
    output logic [CNT_W-1:0]           instr_count,
    output logic                       done,
    output logic                       halted,
    output logic                       timed_out
);

    localparam int          AW   = $clog2(DEPTH);
    localparam int          EW   = PC_W + IR_W;
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    mon_state_t       r_state;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW:0]      r_entries;
    logic             r_overflow;
    logic [CNT_W-1:0] r_instr_count;
    logic [CNT_W-1:0] r_cyc;
    logic             r_rd_ok;
    logic             r_done;
    logic             r_halted;
    logic             r_timed_out;

    logic             w_run;
    logic             w_full;
    logic             w_is_halt;
    logic             w_dup;
    logic             w_write;
    logic             w_timeout_hit;
    logic [AW-1:0]    w_oldest;
    logic [AW-1:0]    w_rd_addr;
    logic [EW-1:0]    w_wdata;
    logic [EW-1:0]    w_ram_q;

    assign w_run         = (r_state == ST_RUN);
    assign w_full        = (r_entries == FULL);
    assign w_wdata       = {pc, ir};
    assign w_is_halt     = (ir[IR_W-1 -: OP_W] == HALT_OP);
    assign w_timeout_hit = (r_cyc == CNT_W'(TIMEOUT_CYC - 1));

`ifdef SISC_TRACE_DEDUP_EN
    logic [EW-1:0] r_last;
    assign w_dup = (r_entries != '0) && (w_wdata == r_last);
`else
    assign w_dup = 1'b0;
`endif

    assign w_write = w_run && ir_valid && !w_dup && !clear;

    // Until the buffer fills, the oldest entry is slot 0; once full, every write
    // overwrites the oldest slot, so the oldest pointer coincides with wr_ptr.
    assign w_oldest  = w_full ? r_wr_ptr : '0;
    assign w_rd_addr = w_oldest + rd_idx;

    sisc_trace_ram #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_write),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_wdata),
        .i_raddr (w_rd_addr),
        .o_rdata (w_ram_q)
    );

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            r_state       <= ST_IDLE;
            r_wr_ptr      <= '0;
            r_entries     <= '0;
            r_overflow    <= 1'b0;
            r_instr_count <= '0;
            r_cyc         <= '0;
            r_rd_ok       <= 1'b0;
            r_done        <= 1'b0;
            r_halted      <= 1'b0;
            r_timed_out   <= 1'b0;
`ifdef SISC_TRACE_DEDUP_EN
            r_last        <= '0;
`endif
        end else if (clear) begin
            r_state       <= ST_IDLE;
            r_wr_ptr      <= '0;
            r_entries     <= '0;
            r_overflow    <= 1'b0;
            r_instr_count <= '0;
            r_cyc         <= '0;
            r_rd_ok       <= 1'b0;
            r_done        <= 1'b0;
            r_halted      <= 1'b0;
            r_timed_out   <= 1'b0;
`ifdef SISC_TRACE_DEDUP_EN
            r_last        <= '0;
`endif
        end else begin
            // Validity of the read issued this cycle, judged against the
            // pre-write entry count so it lines up with the RAM's old data.
            r_rd_ok <= ({1'b0, rd_idx} < r_entries);
            case (r_state)
                ST_IDLE: begin
                    r_cyc   <= '0;
                    r_state <= ST_RUN;
                end
                ST_RUN: begin
                    if (r_cyc != '1) begin
                        r_cyc <= r_cyc + 1'b1;
                    end
                    if (ir_valid) begin
                        if (r_instr_count != '1) begin
                            r_instr_count <= r_instr_count + 1'b1;
                        end
                        if (!w_dup) begin
                            r_wr_ptr <= r_wr_ptr + 1'b1;
                            if (w_full) begin
                                r_overflow <= 1'b1;
                            end else begin
                                r_entries <= r_entries + 1'b1;
                            end
`ifdef SISC_TRACE_DEDUP_EN
                            r_last <= w_wdata;
`endif
                        end
                    end
                    // Halt takes precedence over a coincident timeout.
                    if (ir_valid && w_is_halt) begin
                        r_state  <= ST_HALTED;
                        r_done   <= 1'b1;
                        r_halted <= 1'b1;
                    end else if (w_timeout_hit) begin
                        r_state     <= ST_TIMEOUT;
                        r_done      <= 1'b1;
                        r_timed_out <= 1'b1;
                    end
                end
                default: begin
                    // HALTED / TIMEOUT hold everything until clear or reset.
                end
            endcase
        end
    end

    assign rd_data     = r_rd_ok ? w_ram_q : '0;
    assign entries     = r_entries;
    assign overflow    = r_overflow;
    assign instr_count = r_instr_count;
    assign done        = r_done;
    assign halted      = r_halted;
    assign timed_out   = r_timed_out;

endmodule
